// File: rtl/dark_socv.sv
`timescale 1ns/1ps
// dark_socv: SoC shell with reset conditioning, 8N1 UART TX/RX and a boot banner.
// Optional echo path is compiled in when DARKSOCV_ECHO_EN is defined.
module dark_socv #(
    parameter int BOARD_CK = 100000000,
    parameter int BAUD     = 115200,
    parameter int DIV      = BOARD_CK / BAUD
) (
    input  logic XCLK,
    input  logic XRES,
    input  logic UART_RXD,
    output logic UART_TXD
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 2;
    localparam logic [CW-1:0] L_DIV_M1 = CW'(DIV - 1);
    // The last stop-bit clock is spent in IDLE so back-to-back frames stay contiguous.
    localparam logic [CW-1:0] L_DIV_M2 = CW'(DIV - 2);
    localparam logic [CW-1:0] L_DIV_H  = CW'(DIV / 2);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    function automatic logic [7:0] f_banner(input logic [3:0] idx);
        case (idx)
            4'd0:    f_banner = 8'h64; // d
            4'd1:    f_banner = 8'h61; // a
            4'd2:    f_banner = 8'h72; // r
            4'd3:    f_banner = 8'h6B; // k
            4'd4:    f_banner = 8'h72; // r
            4'd5:    f_banner = 8'h69; // i
            4'd6:    f_banner = 8'h73; // s
            4'd7:    f_banner = 8'h63; // c
            4'd8:    f_banner = 8'h76; // v
            4'd9:    f_banner = 8'h0D;
            4'd10:   f_banner = 8'h0A;
            default: f_banner = 8'h00;
        endcase
    endfunction

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    tx_state_t     r_tx_state, w_tx_state_nx;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_nx;
    logic [2:0]    r_tx_bit, w_tx_bit_nx;
    logic [7:0]    r_tx_sh, w_tx_sh_nx;
    logic          r_txd, w_txd_nx;
    logic          w_tx_accept;
    logic          w_tx_req;
    logic [7:0]    w_tx_data;
    logic [3:0]    r_ban_idx;
    logic          r_ban_done;
    logic          w_ban_sel;
    logic          w_echo_req;
    logic [7:0]    w_echo_data;

    // Reset: asserts asynchronously, releases after two XCLK rising edges.
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) r_rst_sync <= 2'b00;
        else       r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_ban_sel = !r_ban_done;
    assign w_tx_req  = w_ban_sel | w_echo_req;
    assign w_tx_data = w_ban_sel ? f_banner(r_ban_idx) : w_echo_data;
    assign UART_TXD  = r_txd;

    // Banner engine: advance through the ROM once per reset.
    always_ff @(posedge XCLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ban_idx  <= 4'd0;
            r_ban_done <= 1'b0;
        end else if (w_tx_accept && w_ban_sel) begin
            if (r_ban_idx == 4'd10) r_ban_done <= 1'b1;
            else                    r_ban_idx  <= r_ban_idx + 4'd1;
        end
    end

    // TX control state register; TXD idles high and is forced high in reset.
    always_ff @(posedge XCLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_txd      <= w_txd_nx;
        end
    end

    // TX shift register holds data only, no reset needed.
    always_ff @(posedge XCLK) begin
        r_tx_sh <= w_tx_sh_nx;
    end

    // TX next-state: accept in IDLE, then start, 8 data bits LSB first, stop.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_sh_nx    = r_tx_sh;
        w_txd_nx      = r_txd;
        w_tx_accept   = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_txd_nx = 1'b1;
                if (w_tx_req) begin
                    w_tx_accept   = 1'b1;
                    w_tx_sh_nx    = w_tx_data;
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = TX_START;
                    w_txd_nx      = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt == L_DIV_M1) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_bit_nx   = 3'd0;
                    w_txd_nx      = r_tx_sh[0];
                    w_tx_sh_nx    = {1'b1, r_tx_sh[7:1]};
                    w_tx_state_nx = TX_DATA;
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == L_DIV_M1) begin
                    w_tx_cnt_nx = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_txd_nx      = 1'b1;
                        w_tx_state_nx = TX_STOP;
                    end else begin
                        w_tx_bit_nx = r_tx_bit + 3'd1;
                        w_txd_nx    = r_tx_sh[0];
                        w_tx_sh_nx  = {1'b1, r_tx_sh[7:1]};
                    end
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == L_DIV_M2) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = TX_IDLE;
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + 1'b1;
                end
            end
            default: w_tx_state_nx = TX_IDLE;
        endcase
    end

`ifdef DARKSOCV_ECHO_EN
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic          r_rx_s1, r_rx_s2, r_rx_d;
    rx_state_t     r_rx_state, w_rx_state_nx;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_nx;
    logic [2:0]    r_rx_bit, w_rx_bit_nx;
    logic [7:0]    r_rx_sh, w_rx_sh_nx;
    logic          r_rx_vld, w_rx_vld_nx;
    logic          r_hold_full;
    logic [7:0]    r_hold_data;
    logic          w_echo_take;
    logic          w_hold_load;

    // RX synchroniser, edge-detect history and control state.
    always_ff @(posedge XCLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_vld   <= 1'b0;
        end else begin
            r_rx_s1    <= UART_RXD;
            r_rx_s2    <= r_rx_s1;
            r_rx_d     <= r_rx_s2;
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_vld   <= w_rx_vld_nx;
        end
    end

    // RX shift register and echo byte are pure data.
    always_ff @(posedge XCLK) begin
        r_rx_sh <= w_rx_sh_nx;
        if (w_hold_load) r_hold_data <= r_rx_sh;
    end

    // RX next-state: mid-bit check of start, sample each DIV, stop decides validity.
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_sh_nx    = r_rx_sh;
        w_rx_vld_nx   = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_d && !r_rx_s2) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == L_DIV_H) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_bit_nx   = 3'd0;
                    w_rx_state_nx = r_rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == L_DIV_M1) begin
                    w_rx_cnt_nx = '0;
                    w_rx_sh_nx  = {r_rx_s2, r_rx_sh[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_nx = RX_STOP;
                    else                  w_rx_bit_nx   = r_rx_bit + 3'd1;
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == L_DIV_M1) begin
                    w_rx_cnt_nx = '0;
                    if (r_rx_s2) begin
                        w_rx_vld_nx   = 1'b1;
                        w_rx_state_nx = RX_IDLE;
                    end else begin
                        w_rx_state_nx = RX_WAIT;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
            end
            RX_WAIT: begin
                if (r_rx_s2) w_rx_state_nx = RX_IDLE;
            end
            default: w_rx_state_nx = RX_IDLE;
        endcase
    end

    // A full holding register only accepts a new byte in the cycle it is being sent.
    assign w_echo_take = w_tx_accept & !w_ban_sel;
    assign w_hold_load = r_rx_vld & (!r_hold_full | w_echo_take);

    // Echo holding register occupancy.
    always_ff @(posedge XCLK or negedge w_rst_n) begin
        if (!w_rst_n)         r_hold_full <= 1'b0;
        else if (w_hold_load) r_hold_full <= 1'b1;
        else if (w_echo_take) r_hold_full <= 1'b0;
    end

    assign w_echo_req  = r_hold_full;
    assign w_echo_data = r_hold_data;
`else
    logic w_unused_rxd;
    assign w_unused_rxd = UART_RXD;
    assign w_echo_req   = 1'b0;
    assign w_echo_data  = 8'h00;
`endif

endmodule

// File: tb/tb_dark_socv.sv
`timescale 1ns/1ps
// tb_dark_socv: randomized self-checking bench for dark_socv with a UART line decoder model.
module tb_dark_socv;

    localparam int DIV = 32;
    localparam int FR  = 10 * DIV;

    logic XCLK = 1'b0;
    logic XRES = 1'b0;
    logic UART_RXD = 1'b1;
    logic UART_TXD;

    dark_socv #(.BOARD_CK(100000000), .BAUD(115200), .DIV(DIV)) dut (
        .XCLK(XCLK), .XRES(XRES), .UART_RXD(UART_RXD), .UART_TXD(UART_TXD)
    );

    always #5 XCLK = ~XCLK;

    int cyc = 0;
    always @(posedge XCLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ban_exp [11];

    // Line decoder: every frame seen on UART_TXD is pushed into these queues.
    logic [7:0] q_byte[$];
    int         q_t0[$];
    int         q_rise[$];
    logic       q_stop[$];
    bit         mon_active = 1'b0;
    int         mon_t0, mon_rise;
    logic [7:0] mon_byte;

    initial begin
        int k;
        forever begin
            @(negedge XCLK);
            if (!XRES) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (UART_TXD === 1'b0) begin
                    mon_active = 1'b1;
                    mon_t0     = cyc;
                    mon_rise   = -1;
                end
            end else begin
                k = cyc - mon_t0;
                if (mon_rise < 0 && UART_TXD === 1'b1) mon_rise = k;
                if (k >= DIV && k < 9 * DIV && (k % DIV) == DIV / 2) mon_byte[k / DIV - 1] = UART_TXD;
                if (k == 9 * DIV + DIV / 2) begin
                    q_byte.push_back(mon_byte);
                    q_t0.push_back(mon_t0);
                    q_rise.push_back(mon_rise);
                    q_stop.push_back(UART_TXD);
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Low time at frame start: start bit plus trailing zero data bits.
    function automatic int exp_rise(input logic [7:0] b);
        int tz = 0;
        while (tz < 8 && b[tz] == 1'b0) tz++;
        return (1 + tz) * DIV;
    endfunction

    task automatic clear_mon();
        q_byte.delete(); q_t0.delete(); q_rise.delete(); q_stop.delete();
    endtask

    task automatic release_rst(output int rel);
        @(posedge XCLK); #1; XRES = 1'b1; rel = cyc;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int c = 0;
        while (q_byte.size() < n && c < budget) begin
            @(posedge XCLK); c++;
        end
        ok = (q_byte.size() >= n);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, output int s);
        @(posedge XCLK); #1; UART_RXD = 1'b0; s = cyc;
        repeat (DIV) @(posedge XCLK);
        for (int i = 0; i < 8; i++) begin
            #1; UART_RXD = b[i];
            repeat (DIV) @(posedge XCLK);
        end
        #1; UART_RXD = stop;
        repeat (DIV) @(posedge XCLK);
        #1; UART_RXD = 1'b1;
    endtask

    task automatic test_reset();
        int bad = 0;
        XRES = 1'b0; UART_RXD = 1'b1;
        repeat (2) @(posedge XCLK);
        repeat (100) begin
            @(negedge XCLK);
            if (UART_TXD !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0 || q_byte.size() != 0) begin
            n_fail++;
            $display("FAIL reset_hold: %0d low samples, %0d frames; required 0 and 0", bad, q_byte.size());
        end
    endtask

    task automatic test_banner();
        int rel, bad;
        bit ok;
        clear_mon();
        release_rst(rel);
        wait_frames(11, 11 * FR + 20 * DIV, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL banner_frames: got %0d frames, required 11", q_byte.size());
        end else begin
            n_tests++;
            if (q_t0[0] - rel < 1 || q_t0[0] - rel > 4) begin
                n_fail++;
                $display("FAIL banner_latency: start %0d clocks after release, required 1..4", q_t0[0] - rel);
            end
            for (int i = 0; i < 11; i++) begin
                n_tests++;
                if (q_byte[i] !== ban_exp[i]) begin
                    n_fail++;
                    $display("FAIL banner_byte[%0d]: got %h, required %h", i, q_byte[i], ban_exp[i]);
                end
                n_tests++;
                if (q_rise[i] != exp_rise(ban_exp[i]) || q_stop[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL banner_bittime[%0d]: low run %0d stop %b, required %0d and 1", i, q_rise[i], q_stop[i], exp_rise(ban_exp[i]));
                end
                if (i > 0) begin
                    n_tests++;
                    if (q_t0[i] - q_t0[i-1] != FR) begin
                        n_fail++;
                        $display("FAIL banner_gap[%0d]: spacing %0d, required %0d", i, q_t0[i] - q_t0[i-1], FR);
                    end
                end
            end
        end
        bad = 0;
        repeat (3 * FR) begin
            @(negedge XCLK);
            if (UART_TXD !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0 || q_byte.size() != 11) begin
            n_fail++;
            $display("FAIL banner_once: %0d frames, %0d low samples after banner; required 11 and 0", q_byte.size(), bad);
        end
    endtask

    task automatic test_midframe_reset();
        int rel, c;
        bit ok;
        @(posedge XCLK); #1; XRES = 1'b0;
        repeat (3) @(posedge XCLK);
        clear_mon();
        release_rst(rel);
        c = 0;
        while (!(q_byte.size() == 2 && mon_active) && c < 4 * FR) begin
            @(negedge XCLK); c++;
        end
        repeat (4) @(negedge XCLK);
        n_tests++;
        if (UART_TXD !== 1'b0 || q_byte.size() != 2) begin
            n_fail++;
            $display("FAIL midframe_pre: txd %b frames %0d, required 0 and 2", UART_TXD, q_byte.size());
        end
        @(posedge XCLK); #1; XRES = 1'b0;
        #1;
        n_tests++;
        if (UART_TXD !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_abort: txd %b, required 1", UART_TXD);
        end
        repeat (5) @(posedge XCLK);
        clear_mon();
        release_rst(rel);
        wait_frames(11, 11 * FR + 20 * DIV, ok);
        n_tests++;
        if (!ok || q_byte[0] !== 8'h64 || q_t0[0] - rel > 4 || q_byte[10] !== 8'h0A) begin
            n_fail++;
            $display("FAIL midframe_restart: %0d frames, first %h, last %h; required 11, 64, 0a",
                     q_byte.size(), (q_byte.size() > 0) ? q_byte[0] : 8'hxx, (q_byte.size() > 10) ? q_byte[10] : 8'hxx);
        end
        repeat (2 * DIV) @(posedge XCLK);
    endtask

`ifdef DARKSOCV_ECHO_EN
    task automatic test_echo();
        logic [7:0] sent[$];
        int s1, s2, s, lim;
        bit ok;
        clear_mon();
        send_byte(8'h55, 1'b1, s1); sent.push_back(8'h55);
        send_byte(8'hA3, 1'b1, s2); sent.push_back(8'hA3);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            repeat ($urandom_range(0, 3 * DIV)) @(posedge XCLK);
            send_byte(b, 1'b1, s);
            sent.push_back(b);
        end
        wait_frames(6, 4 * FR, ok);
        repeat (2 * FR) @(posedge XCLK);
        n_tests++;
        if (q_byte.size() != 6) begin
            n_fail++;
            $display("FAIL echo_count: got %0d frames, required 6", q_byte.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (q_byte[i] !== sent[i] || q_stop[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL echo_byte[%0d]: got %h, required %h", i, q_byte[i], sent[i]);
                end
            end
            n_tests++;
            if (q_t0[0] < s1 + 9 * DIV || q_t0[0] > s1 + 9 * DIV + DIV / 2 + 8) begin
                n_fail++;
                $display("FAIL echo_latency0: start %0d after send, required %0d..%0d", q_t0[0] - s1, 9 * DIV, 9 * DIV + DIV / 2 + 8);
            end
            lim = (q_t0[0] + FR > s2 + 9 * DIV + DIV / 2 + 8) ? q_t0[0] + FR : s2 + 9 * DIV + DIV / 2 + 8;
            n_tests++;
            if (q_t0[1] < q_t0[0] + FR || q_t0[1] > lim) begin
                n_fail++;
                $display("FAIL echo_latency1: start at %0d, required %0d..%0d", q_t0[1], q_t0[0] + FR, lim);
            end
        end
    endtask

    task automatic test_rx_robust();
        int s;
        bit ok;
        clear_mon();
        @(posedge XCLK); #1; UART_RXD = 1'b0;
        repeat (10) @(posedge XCLK);
        #1; UART_RXD = 1'b1;
        repeat (2 * FR) @(posedge XCLK);
        n_tests++;
        if (q_byte.size() != 0) begin
            n_fail++;
            $display("FAIL rx_glitch: got %0d frames, required 0", q_byte.size());
        end
        send_byte(8'($urandom), 1'b0, s);
        repeat (2 * FR) @(posedge XCLK);
        n_tests++;
        if (q_byte.size() != 0) begin
            n_fail++;
            $display("FAIL rx_framing: got %0d frames, required 0", q_byte.size());
        end
        send_byte(8'h7E, 1'b1, s);
        wait_frames(1, 2 * FR, ok);
        repeat (FR) @(posedge XCLK);
        n_tests++;
        if (q_byte.size() != 1 || q_byte[0] !== 8'h7E) begin
            n_fail++;
            $display("FAIL rx_recover: %0d frames first %h, required 1 and 7e",
                     q_byte.size(), (q_byte.size() > 0) ? q_byte[0] : 8'hxx);
        end
    endtask

    task automatic test_echo_during_banner();
        int rel, s;
        bit ok;
        @(posedge XCLK); #1; XRES = 1'b0;
        repeat (3) @(posedge XCLK);
        clear_mon();
        release_rst(rel);
        repeat (2 * DIV) @(posedge XCLK);
        send_byte(8'h41, 1'b1, s);
        send_byte(8'h42, 1'b1, s);
        wait_frames(12, 13 * FR, ok);
        repeat (3 * FR) @(posedge XCLK);
        n_tests++;
        if (q_byte.size() != 12) begin
            n_fail++;
            $display("FAIL banner_echo_count: got %0d frames, required 12", q_byte.size());
        end else begin
            n_tests++;
            if (q_byte[10] !== 8'h0A || q_byte[11] !== 8'h41) begin
                n_fail++;
                $display("FAIL banner_echo_order: got %h %h, required 0a 41", q_byte[10], q_byte[11]);
            end
            n_tests++;
            if (q_t0[11] - q_t0[10] != FR) begin
                n_fail++;
                $display("FAIL banner_echo_gap: spacing %0d, required %0d", q_t0[11] - q_t0[10], FR);
            end
        end
    endtask
`else
    task automatic test_no_echo();
        int s, bad;
        clear_mon();
        send_byte(8'h55, 1'b1, s);
        send_byte(8'($urandom), 1'b1, s);
        bad = 0;
        repeat (3 * FR) begin
            @(negedge XCLK);
            if (UART_TXD !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0 || q_byte.size() != 0) begin
            n_fail++;
            $display("FAIL no_echo: %0d frames, %0d low samples; required 0 and 0", q_byte.size(), bad);
        end
    endtask
`endif

    initial begin
        string s;
        s = "darkriscv";
        for (int i = 0; i < 9; i++) ban_exp[i] = s[i];
        ban_exp[9]  = 8'h0D;
        ban_exp[10] = 8'h0A;

        test_reset();
        test_banner();
        test_midframe_reset();
`ifdef DARKSOCV_ECHO_EN
        test_echo();
        test_rx_robust();
        test_echo_during_banner();
`else
        test_no_echo();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dark_socv.md
Name: dark_socv

Overview:
- Minimal SoC shell for the darkriscv board top level. Provides clock/reset conditioning, an 8N1 UART transmitter and receiver, and a ROM-driven boot banner.
- After reset it transmits a fixed banner once, then echoes received bytes when echo is enabled.
- Sits directly under the board/simulation top and drives the physical UART pins.

Parameters:
- BOARD_CK, 100000000: input clock frequency in Hz.
- BAUD, 115200: UART bit rate.
- DIV, BOARD_CK/BAUD (integer division, 868 at defaults): clocks per UART bit; must be ≥ 4.

Ports:
- XCLK  input  1  system clock, rising-edge.
- XRES  input  1  reset, asynchronous, active-low.
- UART_RXD  input  1  UART receive line, idle high.
- UART_TXD  output  1  UART transmit line, idle high.

Behaviour:
- Reset: XRES low asserts internal reset immediately. Release is synchronised through a 2-flop chain, so the internal reset deasserts on the 2nd rising XCLK after XRES goes high.
- During reset:
  - UART_TXD = 1
  - banner index = 0
  - TX and RX FSMs in IDLE
  - echo holding register empty
  - baud counters = 0
- Reset asserted mid-frame aborts the frame; UART_TXD returns to 1 asynchronously.
- TX frame format:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit lasts exactly DIV clocks.
  - Frame length 10*DIV clocks.
  - Back-to-back frames allowed with no idle gap.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - A byte is accepted only in IDLE.
  - START begins on the clock after acceptance.
- Banner:
  - ROM of 11 bytes: "darkriscv" followed by 0x0D, 0x0A.
  - Sent exactly once per reset, starting ≤ 2 clocks after internal reset release.
  - Bytes sent in ascending index order.
  - After the last byte the banner engine is done until the next reset.
- RX FSM: IDLE -> START -> DATA(8) -> STOP.
  - Input is double-flop synchronised.
  - Falling edge in IDLE starts the counter; the line is re-checked at DIV/2.
  - If the line is high at that check, it is treated as a glitch and the FSM returns to IDLE.
  - Data bits are sampled every DIV clocks thereafter, LSB first.
  - Stop bit sampled high -> byte valid for 1 clock.
  - Stop bit sampled low -> framing error: byte discarded; the FSM waits for the line to return high before re-arming.
- TX arbitration:
  - Banner has priority over echo.
  - Echo bytes are sent only after the banner has completed.
- Echo holding register: 1 entry.
  - A new RX byte arriving while it is full is dropped; the held byte is kept.
  - RX valid and TX acceptance in the same cycle: the held byte is sent and the new byte loads the register, with no loss.
- UART_TXD is driven directly from a flop; no combinational path from inputs.

Optional Feature:
- Macro DARKSOCV_ECHO_EN.
- Defined: received valid bytes are echoed on UART_TXD as above.
- Undefined:
  - The RX path and holding register are removed.
  - UART_RXD is ignored.
  - Only the banner is ever transmitted, and UART_TXD stays 1 afterwards.

Test Plan:
- Reset hold: XRES=0 for 1 µs with UART_RXD=1 -> UART_TXD=1 throughout; no transitions.
- Banner: release XRES at default parameters -> 11 frames decode as "darkriscv\r\n"; the first start bit falls within 4 clocks of release; each bit is 868 clocks; frames are contiguous.
- Mid-frame reset: drop XRES during the 3rd banner byte -> UART_TXD=1 immediately; after release the banner restarts from 'd'.
- Echo (DARKSOCV_ECHO_EN): after the banner, send 0x55 then 0xA3 on UART_RXD at 115200 -> the same bytes are retransmitted in order, each start bit within 2 clocks of the previous frame end or of byte receipt.
- Echo during banner: send 0x41 while the banner is active -> 0x41 is transmitted immediately after 0x0A. A second byte 0x42 sent before the banner ends is dropped.
- RX robustness: a 100 ns low glitch on UART_RXD -> no echo. A frame with the stop bit low -> no echo, and the next valid frame 0x7E is echoed correctly.
